// File: rtl/fifo_ctrl_sync.sv
// fifo_ctrl_sync: pointer, flag and handshake control for a single-clock
// FIFO whose storage array lives outside (registered rdata, 1-cycle latency).
// Params: DSIZE data width, ASIZE address width (depth 2^ASIZE).
// Ports: clk, rst_n (sync, active-low); push/push_data, pop/pop_data/pop_valid;
//   full, empty, count, overflow, underflow;
//   mem_wen/mem_waddr/mem_wdata, mem_ren/mem_raddr, mem_rdata.
// Option: define FIFO_CTRL_ERR_FLAGS_EN for sticky overflow/underflow flags;
//   undefined ties both flags to 0.
module fifo_ctrl_sync #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [DSIZE-1:0] pop_data,
  output logic             pop_valid,
  output logic             full,
  output logic             empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic             mem_wen,
  output logic             mem_ren,
  output logic [ASIZE-1:0] mem_waddr,
  output logic [ASIZE-1:0] mem_raddr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata
);

  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           push_acc;
  logic           pop_acc;
  logic           pv;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                 (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign count = wptr - rptr;

  // Gating with rst_n keeps memory enables low while reset is held.
  assign pop_acc  = rst_n && pop && !empty;
  // A push into a full FIFO is safe only alongside a pop: the memory
  // reads the old entry at the same edge the new one is written.
  assign push_acc = rst_n && push && (!full || pop_acc);

  assign mem_wen   = push_acc;
  assign mem_waddr = wptr[ASIZE-1:0];
  assign mem_wdata = push_data;
  assign mem_ren   = pop_acc;
  assign mem_raddr = rptr[ASIZE-1:0];

  assign pop_valid = pv;
  assign pop_data  = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      pv   <= 1'b0;
    end else begin
      if (push_acc)
        wptr <= wptr + (ASIZE+1)'(1);
      if (pop_acc)
        rptr <= rptr + (ASIZE+1)'(1);
      pv <= pop_acc;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf;
  logic unf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full && !pop_acc)
        ovf <= 1'b1;
      if (pop && empty)
        unf <= 1'b1;
    end
  end

  assign overflow  = ovf;
  assign underflow = unf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb_fifo_ctrl_sync: directed plus random stimulus against a queue-based
// FIFO model, with a behavioural 1-cycle-latency memory attached.
module tb_fifo_ctrl_sync;

  localparam int DSIZE = 8;
  localparam int ASIZE = 2;
  localparam int DEPTH = 1 << ASIZE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             push = 1'b0;
  logic [DSIZE-1:0] push_data = '0;
  logic             pop = 1'b0;
  logic [DSIZE-1:0] pop_data;
  logic             pop_valid;
  logic             full;
  logic             empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;
  logic             mem_wen;
  logic             mem_ren;
  logic [ASIZE-1:0] mem_waddr;
  logic [ASIZE-1:0] mem_raddr;
  logic [DSIZE-1:0] mem_wdata;
  logic [DSIZE-1:0] mem_rdata = '0;

  fifo_ctrl_sync #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DSIZE-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [DSIZE-1:0] q[$];
  int               n_push = 0;
  int               n_pop = 0;
  bit               m_pv = 0;
  logic [DSIZE-1:0] m_pd = '0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic [DSIZE-1:0] last_pd = '0;

  task automatic post_checks();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (m_pv) check("pop_data", 32'(pop_data), 32'(m_pd));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit p, input logic [DSIZE-1:0] d,
                      input bit po);
    bit pa;
    bit wa;
    bit was_full;
    bit was_empty;
    @(negedge clk);
    push = p;
    push_data = d;
    pop = po;
    was_full = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    pa = po && !was_empty;
    wa = p && (!was_full || pa);
    #1;
    check("mem_wen", 32'(mem_wen), 32'(wa));
    check("mem_ren", 32'(mem_ren), 32'(pa));
    if (wa) begin
      check("waddr", 32'(mem_waddr), 32'(n_push % DEPTH));
      check("wdata", 32'(mem_wdata), 32'(d));
    end
    if (pa) check("raddr", 32'(mem_raddr), 32'(n_pop % DEPTH));
    @(posedge clk);
    m_pv = pa;
    if (pa) begin
      m_pd = q.pop_front();
      last_pd = m_pd;
      n_pop++;
    end
    if (wa) begin
      q.push_back(d);
      n_push++;
    end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    if (p && was_full && !pa) m_ovf = 1;
    if (po && was_empty) m_unf = 1;
`endif
    #1;
    post_checks();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'hEE;
    #1;
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    @(posedge clk);
    q.delete();
    n_push = 0;
    n_pop = 0;
    m_pv = 0;
    m_ovf = 0;
    m_unf = 0;
    #1;
    post_checks();
    @(negedge clk);
    rst_n = 1'b1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  initial begin
    do_reset();
    step(0, 8'h00, 0);
    // Fill, then overflow attempt.
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(1, 8'h44, 0);
    step(1, 8'h55, 0);
    // Full with simultaneous push and pop.
    step(1, 8'h55, 1);
    check("plan_pd11", 32'(last_pd), 32'h11);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    check("plan_pd55", 32'(last_pd), 32'h55);
    // Underflow, then push with pop while empty.
    step(0, 8'h00, 1);
    step(1, 8'hA5, 1);
    step(0, 8'h00, 1);
    check("plan_pdA5", 32'(last_pd), 32'hA5);
    step(0, 8'h00, 0);
    // Ten push/pop pairs crossing the wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h60 + i), 0);
      step(0, 8'h00, 1);
    end
    step(1, 8'h77, 0);
    step(1, 8'h78, 1);
    do_reset();
    step(0, 8'h00, 0);
    // Random traffic with varying push/pop bias and rare resets.
    for (int ph = 0; ph < 8; ph++) begin
      int pp;
      int pq;
      pp = 20 + 20 * (ph % 4);
      pq = 80 - 20 * (ph % 4);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        else step($urandom_range(0, 99) < pp, 8'($urandom),
                  $urandom_range(0, 99) < pq);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_sync.md
# fifo_ctrl_sync

Synchronous FIFO controller: the pointer, flag and handshake logic that drives the single-clock FIFO storage array (`wen`/`ren`/`waddr`/`raddr`/`wdata` in, registered `rdata` out one cycle after `ren`). It accepts push/pop requests from producer and consumer and converts them into accepted memory writes and reads. It maintains wrapped read/write pointers, occupancy, and full/empty status, and returns read data with a valid strobe that matches the memory's one-cycle read latency. Data is not stored here; only control and pass-through paths.

## Interface
- `DSIZE`, 8, data width; passed through to the memory
- `ASIZE`, 4, address width; depth = 2^ASIZE entries
- `clk` input 1: system clock; all logic on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `push` input 1: producer write request
- `push_data` input DSIZE: write data
- `pop` input 1: consumer read request
- `pop_data` output DSIZE: read data; valid only while `pop_valid`=1
- `pop_valid` output 1: one-cycle strobe, cycle after an accepted pop
- `full` output 1: occupancy == 2^ASIZE
- `empty` output 1: occupancy == 0
- `count` output ASIZE+1: current occupancy, 0..2^ASIZE
- `overflow` output 1: sticky, push while full and not popping
- `underflow` output 1: sticky, pop while empty
- `mem_wen` output 1: to memory `wen` (accepted push)
- `mem_ren` output 1: to memory `ren` (accepted pop)
- `mem_waddr` output ASIZE: to memory `waddr`
- `mem_raddr` output ASIZE: to memory `raddr`
- `mem_wdata` output DSIZE: to memory `wdata`
- `mem_rdata` input DSIZE: from memory `rdata`

## Operation
- Pointers `wptr`, `rptr`: ASIZE+1 bits each. Low ASIZE bits give the address; the MSB is the wrap bit. Both increment by 1 modulo 2^(ASIZE+1).
- `empty` = (wptr == rptr). `full` = (MSBs differ, low bits equal). `count` = wptr − rptr, modulo 2^(ASIZE+1).
- `pop_acc` = pop && !empty.
- `push_acc` = push && (!full || pop_acc). A push while full is accepted only together with an accepted pop. The memory reads the old entry at the same edge, so this is safe.
- Push while empty together with pop: push accepted, pop rejected. There is no fall-through.
- Memory drive (combinational):
  - `mem_wen`=push_acc, `mem_waddr`=wptr[ASIZE-1:0], `mem_wdata`=push_data
  - `mem_ren`=pop_acc, `mem_raddr`=rptr[ASIZE-1:0]
- `pop_valid` is a register of pop_acc. `pop_data`=mem_rdata, passed through combinationally.
- Rejected requests change no pointer and assert no memory enable.
- Reset (`rst_n`=0 at an edge):
  - wptr=rptr=0, so `empty`=1, `full`=0, `count`=0
  - `pop_valid`=0, `overflow`=`underflow`=0
  - `mem_wen`=`mem_ren`=0 during reset
  - Reset mid-operation discards all contents and any in-flight pop_valid.

## Timing
- Flags and `count` are derived from the registered pointers. They reflect accepted operations in the cycle after the edge that performs them.
- Read latency: pop accepted in cycle N → `pop_valid`=1 and `pop_data` valid in cycle N+1.
- Back-to-back pops sustain one word per cycle.
- Simultaneous accepted push and pop leave `count`, `full` and `empty` unchanged.
- Wrap-around: address 2^ASIZE−1 → 0 with the wrap bit toggling. There is no bubble at the wrap.

## Configuration
- `FIFO_CTRL_ERR_FLAGS_EN` defined:
  - `overflow` sets on push && full && !pop_acc.
  - `underflow` sets on pop && empty.
  - Both are sticky until reset.
- Undefined: `overflow` and `underflow` are tied to 0, with no flag registers.
- Handshake behaviour is identical in both cases.

## Test plan
- Reset, then idle → `empty`=1, `full`=0, `count`=0, `pop_valid`=0, `mem_wen`=`mem_ren`=0.
- ASIZE=2: push 0x11,0x22,0x33,0x44 → `full`=1, `count`=4. Fifth push 0x55 alone → `mem_wen`=0, `count` stays 4, `overflow`=1 (macro on).
- Full FIFO, push 0x55 with pop in the same cycle → next cycle `pop_valid`=1, `pop_data`=0x11, `count`=4. Draining then returns 0x22,0x33,0x44,0x55.
- Empty FIFO, pop alone → `mem_ren`=0, `pop_valid` stays 0, `underflow`=1 (macro on; 0 with macro off).
- Empty FIFO, push 0xA5 with pop → push accepted, pop rejected, `count`=1. Pop next cycle → `pop_data`=0xA5 one cycle later.
- 10 push/pop pairs across wrap (ASIZE=2) → data in order, addresses 0,1,2,3,0,1… Assert `rst_n`=0 mid-stream → next cycle `empty`=1, `count`=0, flags cleared.
